// File: rtl/haar_stage_scheduler.sv
// rtl/haar_stage_scheduler.sv - Haar cascade stage sequencer for one candidate window
// Rewinds the database, accumulates saturated votes per stage and exits early on reject.
module haar_stage_scheduler #(
  parameter int NUM_STAGES  = 5,
  parameter int SCORE_WIDTH = 16,
  parameter int STAGE_WIDTH = 4
) (
  input  logic                          clk_fpga,
  input  logic                          reset_fpga,
  input  logic                          i_candidate,
  input  logic                          i_abort,
  input  logic [NUM_STAGES-1:0]         i_end_tree,
  input  logic                          i_classifier_valid,
  input  logic signed [SCORE_WIDTH-1:0] i_classifier_value,
  input  logic signed [SCORE_WIDTH-1:0] i_stage_threshold,
  output logic                          o_reset_database,
  output logic                          o_database_request,
  output logic [STAGE_WIDTH-1:0]        o_stage,
  output logic                          o_busy,
  output logic                          o_inspect_done,
  output logic                          o_face,
  output logic [STAGE_WIDTH-1:0]        o_reject_stage
);

  typedef enum logic [2:0] {IDLE, REWIND, RUN, CHECK, DONE} state_t;

  localparam logic signed [SCORE_WIDTH-1:0] SCORE_MAX  = {1'b0, {(SCORE_WIDTH-1){1'b1}}};
  localparam logic signed [SCORE_WIDTH-1:0] SCORE_MIN  = {1'b1, {(SCORE_WIDTH-1){1'b0}}};
  localparam logic [STAGE_WIDTH-1:0]        LAST_STAGE = STAGE_WIDTH'(NUM_STAGES - 1);

  state_t                         state_q, state_d;
  logic signed [SCORE_WIDTH-1:0]  acc_q, acc_d;
  logic signed [SCORE_WIDTH-1:0]  thr_q, thr_d;
  logic [STAGE_WIDTH-1:0]         stage_q, stage_d;
  logic [STAGE_WIDTH-1:0]         reject_q, reject_d;
  logic                           face_q, face_d;
  logic [SCORE_WIDTH:0]           vote_sum;
  logic signed [SCORE_WIDTH-1:0]  vote_sat;
  logic                           end_hit;

  // One extra bit exposes overflow: top two bits differ only when the sum left the signed range.
  always_comb begin
    vote_sum = {acc_q[SCORE_WIDTH-1], acc_q} + {i_classifier_value[SCORE_WIDTH-1], i_classifier_value};
    if (vote_sum[SCORE_WIDTH] != vote_sum[SCORE_WIDTH-1])
      vote_sat = vote_sum[SCORE_WIDTH] ? SCORE_MIN : SCORE_MAX;
    else
      vote_sat = vote_sum[SCORE_WIDTH-1:0];
  end

  always_comb begin
    end_hit = 1'b0;
    for (int s = 0; s < NUM_STAGES; s++)
      if (stage_q == STAGE_WIDTH'(s)) end_hit = i_end_tree[s];
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    thr_d    = thr_q;
    stage_d  = stage_q;
    reject_d = reject_q;
    face_d   = face_q;
    if (i_abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (i_candidate) begin
          state_d = REWIND;
          acc_d   = '0;
          stage_d = '0;
        end
        REWIND: state_d = RUN;
        RUN: begin
          if (i_classifier_valid) acc_d = vote_sat;
          if (end_hit) begin
            thr_d   = i_stage_threshold;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (acc_q < thr_q) begin
            state_d  = DONE;
            face_d   = 1'b0;
            reject_d = stage_q;
          end else if (stage_q == LAST_STAGE) begin
            state_d = DONE;
            face_d  = 1'b1;
          end else begin
            state_d = RUN;
            stage_d = stage_q + 1'b1;
            acc_d   = '0;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    o_reset_database   = (state_q == REWIND);
    o_database_request = (state_q == RUN);
    o_busy             = (state_q != IDLE);
    o_inspect_done     = (state_q == DONE);
    o_stage            = stage_q;
    o_face             = face_q;
    o_reject_stage     = reject_q;
  end

  always_ff @(posedge clk_fpga or posedge reset_fpga) begin
    if (reset_fpga) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      thr_q    <= '0;
      stage_q  <= '0;
      reject_q <= '0;
      face_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      thr_q    <= thr_d;
      stage_q  <= stage_d;
      reject_q <= reject_d;
      face_q   <= face_d;
    end
  end

endmodule
